data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU load/store port (C) and the UART programmer / debug loader port (U).
- Sits between the CPU memory-segment decode and the data_mem block RAM.
- Issues at most one memory command per cycle and returns read data to the owning requester one cycle later.
- CPU has priority by default. A starvation counter and a U-side lock give U guaranteed bandwidth and atomic bursts.

Parameters:
- ADDR_W, 17, word-address width to memory.
- MAX_WAIT, 8, consecutive denied cycles of U before U gets priority (range 1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- c_req  in  1  CPU request.
- c_we  in  1  CPU write (1) / read (0).
- c_addr  in  ADDR_W  CPU word address.
- c_wdata  in  32  CPU write data.
- c_gnt  out  1  CPU accepted this cycle.
- c_rvalid  out  1  CPU read data valid.
- c_rdata  out  32  CPU read data.
- u_req, u_we, u_addr, u_wdata, u_gnt, u_rvalid, u_rdata: same as the c_ signals, for U.
- u_lock  in  1  while U holds the grant, keep it until u_lock falls.
- mem_en  out  1  memory command strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data (synchronous, 1-cycle latency).

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt.
  - A transfer occurs in the cycle where req && gnt.
  - gnt is combinational from req and the registered state. At most one gnt is high per cycle.
- Memory command:
  - In the grant cycle: mem_en=1, and mem_we/mem_addr/mem_wdata come from the winner.
  - With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - A granted read sets the winner's rvalid exactly 1 cycle later, with rdata = mem_rdata.
  - Writes produce no rvalid.
  - The loser's rdata is held at its last value. rvalid is a 1-cycle pulse.
- FSM states:
  - C_PRI (reset state): C wins if c_req, otherwise U wins if u_req.
    - U granted with u_lock=1 -> U_LOCK.
    - starve_cnt reaches MAX_WAIT -> U_PRI.
  - U_PRI: U wins if u_req, otherwise C wins.
    - Return to C_PRI after a U grant with u_lock=0.
    - A U grant with u_lock=1 -> U_LOCK.
    - u_req=0 -> C_PRI.
  - U_LOCK: only U can be granted; c_gnt=0 even if c_req.
    - Exit to C_PRI in the first cycle u_lock=0, evaluated at the clock edge. C can win from the next cycle.
- starve_cnt (8-bit):
  - Increments each cycle u_req=1 and u_gnt=0, saturating at MAX_WAIT.
  - Cleared on any u_gnt, or when u_req=0.
- Simultaneous c_req && u_req:
  - C_PRI wins for C, U_PRI wins for U, U_LOCK wins for U.
  - Same-cycle back-to-back grants to different ports are legal. The rvalid pipeline stage is tagged with the owner, so there is no mix-up.
- Reset values:
  - All outputs 0: c_rdata, u_rdata, rvalids, gnts, mem_*.
  - State C_PRI, starve_cnt 0, pending-read tag cleared.
- Reset mid-operation: a read granted in the cycle rst rises produces no rvalid afterwards.

Optional Feature:
- ARB_STATS_EN defined:
  - Adds outputs c_grant_cnt[31:0], u_grant_cnt[31:0], conflict_cnt[31:0].
  - The counts are grants per port and cycles with c_req && u_req.
  - Counters wrap modulo 2^32 and are cleared by rst.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Lone C read: c_req=1, c_we=0, c_addr=0x10; memory word 0x10 = 0xDEADBEEF -> c_gnt same cycle; c_rvalid=1, c_rdata=0xDEADBEEF next cycle; u_rvalid stays 0.
- Contention: c_req and u_req held high continuously, MAX_WAIT=8 -> C granted cycles 0..7, U granted cycle 8, C again cycle 9; starve_cnt back to 0 after cycle 8.
- Lock burst:
  - Stimulus: U writes 4 words 0x100..0x103 with u_lock=1 while c_req=1.
  - Response: c_gnt=0 for all 4 cycles; u_lock drops after the 4th write; c_gnt=1 the following cycle.
- Back-to-back mixed reads: C read at cycle n, U read at cycle n+1 -> c_rvalid at n+1 and u_rvalid at n+2, with correct separate data; no cross-delivery.
- Reset mid-read: grant U read, assert rst the same cycle -> u_rvalid=0 after reset; state C_PRI; all mem_* 0.
- ARB_STATS_EN: 10 contention cycles with MAX_WAIT=8 -> c_grant_cnt=9, u_grant_cnt=1, conflict_cnt=10.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the block RAM.
// ARB_STATS_EN adds the grant/conflict statistics outputs.
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 17
);
  localparam int unsigned DATA_W = 32;

  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              u_req;
  logic              u_we;
  logic [ADDR_W-1:0] u_addr;
  logic [DATA_W-1:0] u_wdata;
  logic              u_lock;
  logic              u_gnt;
  logic              u_rvalid;
  logic [DATA_W-1:0] u_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

`ifdef ARB_STATS_EN
  logic [31:0] c_grant_cnt;
  logic [31:0] u_grant_cnt;
  logic [31:0] conflict_cnt;
`endif

  // Arbiter side
  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  u_req, u_we, u_addr, u_wdata, u_lock,
    output u_gnt, u_rvalid, u_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
`ifdef ARB_STATS_EN
    ,
    output c_grant_cnt, u_grant_cnt, conflict_cnt
`endif
  );

  // Requester / memory side
  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output u_req, u_we, u_addr, u_wdata, u_lock,
    input  u_gnt, u_rvalid, u_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
`ifdef ARB_STATS_EN
    ,
    input  c_grant_cnt, u_grant_cnt, conflict_cnt
`endif
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter (CPU priority, UART loader with starvation guard and lock) in front
// of the single-port data RAM. ARB_STATS_EN adds grant/conflict counters.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {C_PRI = 2'd0, U_PRI = 2'd1, U_LOCK = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               c_pend_q, u_pend_q;
  logic [DATA_W-1:0]  c_rdata_q, u_rdata_q;
  logic [DATA_W-1:0]  c_rdata_d, u_rdata_d;
  logic               c_win, u_win;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= C_PRI;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      C_PRI: begin
        if (u_win && bus.u_lock)                 state_d = U_LOCK;
        else if (starve_d == CNT_W'(MAX_WAIT))  state_d = U_PRI;
      end
      U_PRI: begin
        if (u_win)            state_d = bus.u_lock ? U_LOCK : C_PRI;
        else if (!bus.u_req)  state_d = C_PRI;
      end
      U_LOCK: begin
        if (!bus.u_lock) state_d = C_PRI;
      end
      default: state_d = C_PRI;
    endcase
  end

  // Grants and memory command
  always_comb begin
    c_win         = 1'b0;
    u_win         = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state_q)
      C_PRI: begin
        c_win = bus.c_req;
        u_win = bus.u_req & ~bus.c_req;
      end
      U_PRI: begin
        u_win = bus.u_req;
        c_win = bus.c_req & ~bus.u_req;
      end
      U_LOCK: u_win = bus.u_req;
      default: ;
    endcase
    if (c_win) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.c_we;
      bus.mem_addr  = bus.c_addr;
      bus.mem_wdata = bus.c_wdata;
    end else if (u_win) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.u_we;
      bus.mem_addr  = bus.u_addr;
      bus.mem_wdata = bus.u_wdata;
    end
  end

  assign bus.c_gnt = c_win;
  assign bus.u_gnt = u_win;

  // Starvation counter: counts denied U cycles, saturating at MAX_WAIT
  always_comb begin
    starve_d = starve_q;
    if (!bus.u_req || u_win)                 starve_d = '0;
    else if (starve_q != CNT_W'(MAX_WAIT))   starve_d = starve_q + CNT_W'(1);
  end

  // RAM data lands in the cycle after the grant; the owner tag steers it, the other side holds
  assign c_rdata_d    = c_pend_q ? bus.mem_rdata : c_rdata_q;
  assign u_rdata_d    = u_pend_q ? bus.mem_rdata : u_rdata_q;
  assign bus.c_rdata  = c_rdata_d;
  assign bus.u_rdata  = u_rdata_d;
  assign bus.c_rvalid = c_pend_q;
  assign bus.u_rvalid = u_pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      c_pend_q  <= 1'b0;
      u_pend_q  <= 1'b0;
      c_rdata_q <= '0;
      u_rdata_q <= '0;
    end else begin
      starve_q  <= starve_d;
      c_pend_q  <= c_win & ~bus.c_we;
      u_pend_q  <= u_win & ~bus.u_we;
      c_rdata_q <= c_rdata_d;
      u_rdata_q <= u_rdata_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] c_grant_cnt_q, u_grant_cnt_q, conflict_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_grant_cnt_q  <= '0;
      u_grant_cnt_q  <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (c_win)                   c_grant_cnt_q  <= c_grant_cnt_q + 32'(1);
      if (u_win)                   u_grant_cnt_q  <= u_grant_cnt_q + 32'(1);
      if (bus.c_req && bus.u_req)  conflict_cnt_q <= conflict_cnt_q + 32'(1);
    end
  end

  assign bus.c_grant_cnt  = c_grant_cnt_q;
  assign bus.u_grant_cnt  = u_grant_cnt_q;
  assign bus.conflict_cnt = conflict_cnt_q;
`endif
endmodule
